// File: rtl/alu_seq_if.sv
// Operand/result bundle between the register-file read ports, the ALU and write-back.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] ain;
  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] out;
  logic [2:0]       status;
  logic             busy;
  logic             done;

  modport master (
    output start, op, ain, bin,
    input  out, status, busy, done
  );

  modport slave (
    input  start, op, ain, bin,
    output out, status, busy, done
  );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU: single-cycle add/sub/logic/shift, iterative shift-add unsigned multiply.
// Status is {N, V, Z}; done pulses for one cycle whenever out/status are rewritten.
module alu_seq #(
  parameter int unsigned WIDTH = 16
) (
  input logic       clk,
  input logic       reset,
  alu_seq_if.slave  bus
);

  localparam int unsigned CntW = $clog2(WIDTH);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpNot = 3'b011;
  localparam logic [2:0] OpOr  = 3'b100;
  localparam logic [2:0] OpXor = 3'b101;
  localparam logic [2:0] OpShl = 3'b110;
  localparam logic [2:0] OpMul = 3'b111;

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     out_q, out_d;
  logic [2:0]           status_q, status_d;
  logic                 done_q, done_d;

  logic [WIDTH-1:0]     alu_res;
  logic                 alu_v;
  logic [2*WIDTH-1:0]   addend;
  logic [2*WIDTH-1:0]   acc_sum;

  // Single-cycle datapath; V only meaningful for ADD/SUB.
  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    unique case (bus.op)
      OpAdd: begin
        alu_res = bus.ain + bus.bin;
        alu_v   = (bus.ain[WIDTH-1] == bus.bin[WIDTH-1]) &&
                  (alu_res[WIDTH-1] != bus.ain[WIDTH-1]);
      end
      OpSub: begin
        alu_res = bus.ain - bus.bin;
        alu_v   = (bus.ain[WIDTH-1] != bus.bin[WIDTH-1]) &&
                  (alu_res[WIDTH-1] != bus.ain[WIDTH-1]);
      end
      OpAnd:   alu_res = bus.ain & bus.bin;
      OpNot:   alu_res = ~bus.bin;
      OpOr:    alu_res = bus.ain | bus.bin;
      OpXor:   alu_res = bus.ain ^ bus.bin;
      OpShl:   alu_res = bus.ain << bus.bin[CntW-1:0];
      OpMul:   alu_res = '0;
      default: alu_res = '0;
    endcase
  end

  // Multiplier bit cnt_q selects multiplicand << cnt_q.
  assign addend  = mplier_q[cnt_q] ? (mcand_q << cnt_q) : '0;
  assign acc_sum = acc_q + addend;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    out_d    = out_q;
    status_d = status_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (bus.op == OpMul) begin
            mcand_d  = {{WIDTH{1'b0}}, bus.ain};
            mplier_d = bus.bin;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = StMul;
          end else begin
            out_d    = alu_res;
            status_d = {alu_res[WIDTH-1], alu_v, (alu_res == '0)};
            done_d   = 1'b1;
          end
        end
      end
      StMul: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(WIDTH - 1)) begin
          out_d    = acc_sum[WIDTH-1:0];
          status_d = {acc_sum[WIDTH-1], (|acc_sum[2*WIDTH-1:WIDTH]),
                      (acc_sum[WIDTH-1:0] == '0)};
          done_d   = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      out_q    <= '0;
      status_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      out_q    <= out_d;
      status_q <= status_d;
      done_q   <= done_d;
    end
  end

  assign bus.out    = out_q;
  assign bus.status = status_q;
  assign bus.busy   = (state_q == StMul);
  assign bus.done   = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed corner cases plus randomized ops against an arithmetic model.
module tb_alu_seq;

  localparam int unsigned W  = 16;
  localparam int unsigned LW = $clog2(W);

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns {N, V, Z, result} from plain integer arithmetic.
  function automatic logic [W+2:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    longint         sa, sb, s, smax, smin;
    logic [2*W-1:0] p;
    logic [W-1:0]   r;
    logic           v;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    smax = (longint'(1) << (W - 1)) - 1;
    smin = -(longint'(1) << (W - 1));
    v    = 1'b0;
    r    = '0;
    case (op)
      3'd0: begin r = a + b; s = sa + sb; v = (s > smax) || (s < smin); end
      3'd1: begin r = a - b; s = sa - sb; v = (s > smax) || (s < smin); end
      3'd2: r = a & b;
      3'd3: r = ~b;
      3'd4: r = a | b;
      3'd5: r = a ^ b;
      3'd6: r = a << b[LW-1:0];
      default: begin
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        r = p[W-1:0];
        v = (p[2*W-1:W] != '0);
      end
    endcase
    return {r[W-1], v, (r == '0), r};
  endfunction

  function automatic logic [W-1:0] rnd_val();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = '0;
      1:       v = 16'h7FFF;
      2:       v = 16'h8000;
      3:       v = 16'hFFFF;
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  task automatic single(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, output logic [W-1:0] o, output logic [2:0] s);
    logic [W+2:0] m;
    m = model(op, a, b);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.ain = a; bus.bin = b;
    @(negedge clk);
    bus.start = 1'b0;
    o = bus.out;
    s = bus.status;
    check({tag, ".done"}, 32'(bus.done), 32'd1);
    check({tag, ".out"}, 32'(o), 32'(m[W-1:0]));
    check({tag, ".status"}, 32'(s), 32'(m[W+2:W]));
    @(negedge clk);
    check({tag, ".done_once"}, 32'(bus.done), 32'd0);
  endtask

  // inj > 0: an ADD 1+1 request is sampled at edge k+inj while the multiply runs.
  task automatic run_mul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int inj, output logic [W-1:0] o, output logic [2:0] s);
    logic [W+2:0] m;
    int busy_n, done_n, done_at;
    logic busy_at_done;
    m = model(3'd7, a, b);
    busy_n = 0; done_n = 0; done_at = 0; busy_at_done = 1'b1;
    o = '0; s = '0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd7; bus.ain = a; bus.bin = b;
    for (int n = 1; n <= int'(W) + 4; n++) begin
      @(negedge clk);
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_n++; done_at = n; o = bus.out; s = bus.status; busy_at_done = bus.busy;
      end
      if (n + 1 == inj) begin
        bus.start = 1'b1; bus.op = 3'd0; bus.ain = 16'd1; bus.bin = 16'd1;
      end else begin
        bus.start = 1'b0;
      end
    end
    check({tag, ".busy_cycles"}, 32'(busy_n), 32'(W));
    check({tag, ".done_count"}, 32'(done_n), 32'd1);
    check({tag, ".done_cycle"}, 32'(done_at), 32'(W + 1));
    check({tag, ".busy_at_done"}, 32'(busy_at_done), 32'd0);
    check({tag, ".out"}, 32'(o), 32'(m[W-1:0]));
    check({tag, ".status"}, 32'(s), 32'(m[W+2:W]));
  endtask

  initial begin
    logic [W-1:0] o;
    logic [2:0]   s;
    logic [2:0]   rop;
    logic [W-1:0] ra, rb;
    logic [W+2:0] exp_q [$];
    logic [W+2:0] e;

    errors = 0;
    checks = 0;
    reset = 1'b1;
    bus.start = 1'b0; bus.op = '0; bus.ain = '0; bus.bin = '0;
    repeat (2) @(negedge clk);
    check("rst.out", 32'(bus.out), 32'h0);
    check("rst.status", 32'(bus.status), 32'h0);
    check("rst.busy", 32'(bus.busy), 32'h0);
    check("rst.done", 32'(bus.done), 32'h0);
    reset = 1'b0;

    single("add_ovf", 3'd0, 16'h7FFF, 16'h0001, o, s);
    check("add_ovf.lit_out", 32'(o), 32'h8000);
    check("add_ovf.lit_status", 32'(s), 32'b110);
    single("sub_zero", 3'd1, 16'h0005, 16'h0005, o, s);
    check("sub_zero.lit_out", 32'(o), 32'h0000);
    check("sub_zero.lit_status", 32'(s), 32'b001);
    single("sub_ovf", 3'd1, 16'h8000, 16'h0001, o, s);
    check("sub_ovf.lit_out", 32'(o), 32'h7FFF);
    check("sub_ovf.lit_status", 32'(s), 32'b010);
    single("and", 3'd2, 16'hF0F0, 16'h0FF0, o, s);
    check("and.lit_out", 32'(o), 32'h00F0);
    single("not", 3'd3, 16'h1234, 16'h0000, o, s);
    check("not.lit_out", 32'(o), 32'hFFFF);
    check("not.lit_status", 32'(s), 32'b100);
    single("shl", 3'd6, 16'h0001, 16'h0013, o, s);
    check("shl.lit_out", 32'(o), 32'h0008);
    check("shl.lit_status", 32'(s), 32'b000);

    run_mul("mul3x5", 16'h0003, 16'h0005, 0, o, s);
    check("mul3x5.lit_out", 32'(o), 32'h000F);
    check("mul3x5.lit_status", 32'(s), 32'b000);
    run_mul("mul_ovf_inj", 16'h0100, 16'h0100, 5, o, s);
    check("mul_ovf_inj.lit_out", 32'(o), 32'h0000);
    check("mul_ovf_inj.lit_status", 32'(s), 32'b011);

    // Back-to-back single-cycle ops: one result per cycle.
    for (int j = 0; j <= 8; j++) begin
      @(negedge clk);
      if (j > 0) begin
        e = exp_q.pop_front();
        check("b2b.done", 32'(bus.done), 32'd1);
        check("b2b.out", 32'(bus.out), 32'(e[W-1:0]));
        check("b2b.status", 32'(bus.status), 32'(e[W+2:W]));
      end
      if (j < 8) begin
        rop = 3'($urandom_range(0, 6)); ra = rnd_val(); rb = rnd_val();
        exp_q.push_back(model(rop, ra, rb));
        bus.start = 1'b1; bus.op = rop; bus.ain = ra; bus.bin = rb;
      end else begin
        bus.start = 1'b0;
      end
    end

    for (int i = 0; i < 30; i++) begin
      rop = 3'($urandom_range(0, 7)); ra = rnd_val(); rb = rnd_val();
      if (rop == 3'd7) run_mul("rnd_mul", ra, rb, 0, o, s);
      else single("rnd_op", rop, ra, rb, o, s);
    end

    // Asynchronous reset mid-cycle while done is high.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd0; bus.ain = 16'd1; bus.bin = 16'd2;
    @(negedge clk);
    bus.start = 1'b0;
    check("pre_rst.out", 32'(bus.out), 32'h3);
    check("pre_rst.done", 32'(bus.done), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_rst.out", 32'(bus.out), 32'h0);
    check("async_rst.status", 32'(bus.status), 32'h0);
    check("async_rst.busy", 32'(bus.busy), 32'h0);
    check("async_rst.done", 32'(bus.done), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Reset during a multiply aborts it with no done pulse.
    single("pre_mul", 3'd0, 16'h1234, 16'h0001, o, s);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd7; bus.ain = 16'd3; bus.bin = 16'd5;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    check("mul_abort.busy_before", 32'(bus.busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mul_abort.busy", 32'(bus.busy), 32'd0);
    check("mul_abort.out", 32'(bus.out), 32'h0);
    check("mul_abort.done", 32'(bus.done), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < int'(W) + 2; n++) begin
      @(negedge clk);
      check("mul_abort.no_done", 32'(bus.done), 32'd0);
    end
    single("post_rst_add", 3'd0, 16'h0002, 16'h0002, o, s);
    check("post_rst_add.lit_out", 32'(o), 32'h0004);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
